// File: rtl/dds_dac_tx.sv
// DDS sine generator driving a 14-bit offset-binary DAC: phase accumulator,
// quarter-wave ROM, amplitude scaling, 5-stage output pipeline and run/burst FSM.
module dds_dac_tx #(
  parameter int PHASE_W  = 32,
  parameter int DATA_W   = 14,
  parameter int LUT_AW   = 8,
  parameter int WAKE_CYC = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [13:0]        cfg_amp,
  input  logic [15:0]        cfg_cycles,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  da_data,
  output logic               da_valid,
  output logic               period_tick,
  output logic               da_clk,
  output logic               da_sleep
);

  localparam int AMP_W  = 14;
  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = DATA_W + AMP_W + 1;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam logic [AMP_W-1:0]  AMP_UNITY  = 14'd8192;
  localparam logic [MAG_W-1:0]  MAG_MAX    = {MAG_W{1'b1}};
  localparam logic [DATA_W-1:0] MID_C      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [7:0]        WAKE_LAST  = 8'(WAKE_CYC - 1);
  localparam logic [7:0]        DRAIN_LAST = 8'd4;
  localparam logic [127:0]      PI_Q60     = 128'h3243F6A8885A308D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // round(MAG_MAX * sin(pi/2 * k / LUT_N)) via a Q60 Taylor series, evaluated at elaboration
  function automatic logic [MAG_W-1:0] sin_lut(input int k);
    logic [127:0] x, x2, term, acc;
    x    = (PI_Q60 * 128'(k)) >> (LUT_AW + 1);
    x2   = (x * x) >> 60;
    term = x;
    acc  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n[0]) acc = acc - term;
      else      acc = acc + term;
    end
    return MAG_W'((acc * 128'(MAG_MAX) + (128'd1 << 59)) >> 60);
  endfunction

  state_t               state_r, state_nx_s;
  logic [7:0]           seq_cnt_r;
  logic [PHASE_W-1:0]   ftw_r, phase_r;
  logic [AMP_W-1:0]     amp_r;
  logic [15:0]          cyc_n_r, wrap_cnt_r, wrap_cnt_nx_s;
  logic [PHASE_W:0]     sum_s;
  logic                 wrap_s, stop_any_s, term_s, stop_pend_r, tick_pend_r;
  logic                 cfg_ready_r, busy_r, done_r, da_sleep_r;
  logic                 iss_v_s, iss_t_s;
  logic [1:0]           s1_q_r;
  logic [LUT_AW-1:0]    s1_idx_r, addr_s;
  logic [MAG_W-1:0]     lut_s [LUT_N];
  logic [MAG_W-1:0]     mag_s, s2_mag_r;
  logic signed [DATA_W:0] mag_ext_s, s3_s_r;
  logic signed [PROD_W-1:0] mul_a_s, mul_b_s, prod_s;
  logic [DATA_W-1:0]    s4_r, da_data_r;
  logic                 s1_v_r, s2_v_r, s3_v_r, s4_v_r, da_valid_r;
  logic                 s1_t_r, s2_t_r, s3_t_r, s4_t_r, period_tick_r;
  logic                 s2_neg_r;

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [MAG_W-1:0] LV = sin_lut(gi);
    assign lut_s[gi] = LV;
  end

  assign sum_s         = {1'b0, phase_r} + {1'b0, ftw_r};
  assign wrap_s        = sum_s[PHASE_W];
  assign wrap_cnt_nx_s = wrap_cnt_r + 16'd1;
  assign stop_any_s    = stop_pend_r | stop;
  // with ftw == 0 the accumulator never wraps, so a pending stop ends the run at once
  assign term_s = (wrap_s && (((cyc_n_r != 16'd0) && (wrap_cnt_nx_s == cyc_n_r)) || stop_any_s))
                || (stop_any_s && (ftw_r == {PHASE_W{1'b0}}));
  assign iss_v_s = (state_r == ST_RUN);
  assign iss_t_s = iss_v_s & tick_pend_r;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_r <= ST_IDLE;
    else         state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_nx_s = ST_WAKE;  else state_nx_s = ST_IDLE;
      ST_WAKE:  if (seq_cnt_r == WAKE_LAST) state_nx_s = ST_RUN; else state_nx_s = ST_WAKE;
      ST_RUN:   if (term_s) state_nx_s = ST_DRAIN; else state_nx_s = ST_RUN;
      ST_DRAIN: if (seq_cnt_r == DRAIN_LAST) state_nx_s = ST_IDLE; else state_nx_s = ST_DRAIN;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // wake/drain dwell counter, restarted on every state change
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                                          seq_cnt_r <= 8'd0;
    else if (state_nx_s != state_r)                       seq_cnt_r <= 8'd0;
    else if (state_r == ST_WAKE || state_r == ST_DRAIN)   seq_cnt_r <= seq_cnt_r + 8'd1;
    else                                                  seq_cnt_r <= 8'd0;
  end

  // control outputs, registered from the next state
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      da_sleep_r  <= 1'b1;
    end else begin
      cfg_ready_r <= (state_nx_s == ST_IDLE);
      busy_r      <= (state_nx_s != ST_IDLE);
      done_r      <= (state_r == ST_DRAIN) && (state_nx_s == ST_IDLE);
      da_sleep_r  <= (state_nx_s == ST_IDLE);
    end
  end

  // shadow configuration, amplitude saturated to unity on capture
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ftw_r   <= {PHASE_W{1'b0}};
      amp_r   <= 14'd0;
      cyc_n_r <= 16'd0;
    end else if (cfg_valid && cfg_ready_r) begin
      ftw_r   <= cfg_ftw;
      amp_r   <= (cfg_amp > AMP_UNITY) ? AMP_UNITY : cfg_amp;
      cyc_n_r <= cfg_cycles;
    end
  end

  // phase accumulator, wrap counter, pending stop and period-start marker
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_r     <= {PHASE_W{1'b0}};
      wrap_cnt_r  <= 16'd0;
      tick_pend_r <= 1'b0;
      stop_pend_r <= 1'b0;
    end else begin
      if (state_r == ST_RUN) begin
        phase_r     <= sum_s[PHASE_W-1:0];
        tick_pend_r <= wrap_s;
        if (wrap_s) wrap_cnt_r <= wrap_cnt_nx_s;
      end else begin
        phase_r     <= {PHASE_W{1'b0}};
        wrap_cnt_r  <= 16'd0;
        tick_pend_r <= 1'b1;
      end
      stop_pend_r <= ((state_r == ST_WAKE) || (state_r == ST_RUN)) && stop_any_s;
    end
  end

  // quadrant mirroring: odd quadrants read the table backwards, idx 0 maps to the peak
  always_comb begin
    addr_s = s1_idx_r;
    mag_s  = lut_s[s1_idx_r];
    if (s1_q_r[0]) begin
      addr_s = LUT_AW'(0) - s1_idx_r;
      if (s1_idx_r == {LUT_AW{1'b0}}) mag_s = MAG_MAX;
      else                            mag_s = lut_s[addr_s];
    end else begin
      addr_s = s1_idx_r;
      mag_s  = lut_s[s1_idx_r];
    end
  end

  assign mag_ext_s = {2'b00, s2_mag_r};
  assign mul_a_s   = PROD_W'(s3_s_r);
  assign mul_b_s   = PROD_W'({1'b0, amp_r});
  assign prod_s    = mul_a_s * mul_b_s;

  // five-stage sample pipeline with valid/tick sidebands
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {s1_v_r, s2_v_r, s3_v_r, s4_v_r, da_valid_r}    <= 5'd0;
      {s1_t_r, s2_t_r, s3_t_r, s4_t_r, period_tick_r} <= 5'd0;
      s1_q_r    <= 2'd0;
      s1_idx_r  <= {LUT_AW{1'b0}};
      s2_mag_r  <= {MAG_W{1'b0}};
      s2_neg_r  <= 1'b0;
      s3_s_r    <= '0;
      s4_r      <= {DATA_W{1'b0}};
      da_data_r <= MID_C;
    end else begin
      {s1_v_r, s2_v_r, s3_v_r, s4_v_r, da_valid_r}    <= {iss_v_s, s1_v_r, s2_v_r, s3_v_r, s4_v_r};
      {s1_t_r, s2_t_r, s3_t_r, s4_t_r, period_tick_r} <= {iss_t_s, s1_t_r, s2_t_r, s3_t_r, s4_t_r};
      {s1_q_r, s1_idx_r} <= phase_r[PHASE_W-1 -: LUT_AW+2];
      s2_mag_r  <= mag_s;
      s2_neg_r  <= s1_q_r[1];
      s3_s_r    <= s2_neg_r ? -mag_ext_s : mag_ext_s;
      s4_r      <= DATA_W'(prod_s >>> (AMP_W - 1));
      da_data_r <= s4_v_r ? (s4_r + MID_C) : MID_C;
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign da_sleep    = da_sleep_r;
  assign da_data     = da_data_r;
  assign da_valid    = da_valid_r;
  assign period_tick = period_tick_r;
  assign da_clk      = ~sys_clk;

endmodule

// File: tb/tb_dds_dac_tx.sv
// Scoreboard bench for dds_dac_tx: a reference model queues the expected sample
// stream when a run is started; a monitor pops and compares each valid sample.
module tb_dds_dac_tx;

  logic        sys_clk = 1'b0;
  logic        sys_rst, cfg_valid, cfg_ready, start, stop, busy, done;
  logic [31:0] cfg_ftw;
  logic [13:0] cfg_amp, da_data;
  logic [15:0] cfg_cycles;
  logic        da_valid, period_tick, da_clk, da_sleep;

  int n_cmp = 0, n_bad = 0, cyc = 0, first_cyc = -1, n_seen = 0;
  bit mon_en = 1'b0;
  logic [14:0] sb_q [$];
  logic [31:0] sh_ftw = 32'd0;
  logic [13:0] sh_amp = 14'd0;
  logic [15:0] sh_cyc = 16'd0;

  dds_dac_tx dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_amp(cfg_amp), .cfg_cycles(cfg_cycles), .start(start), .stop(stop),
    .busy(busy), .done(done), .da_data(da_data), .da_valid(da_valid),
    .period_tick(period_tick), .da_clk(da_clk), .da_sleep(da_sleep)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lut_ref(input int k);
    real v;
    v = 8191.0 * $sin(3.14159265358979323846 * k / 512.0);
    return $rtoi(v + 0.5);
  endfunction

  function automatic logic [13:0] exp_sample(input logic [31:0] ph, input logic [13:0] amp);
    int p, q, idx, mag, s, r;
    p   = int'(ph[31:22]);
    q   = p / 256;
    idx = p % 256;
    mag = (q == 1 || q == 3) ? lut_ref(256 - idx) : lut_ref(idx);
    s   = (q >= 2) ? -mag : mag;
    r   = (s * int'(amp)) >>> 13;
    return 14'(r + 8192);
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_da_data", da_data, 32'h2000);
    check("rst_da_valid", da_valid, 0);
    check("rst_tick", period_tick, 0);
    check("rst_sleep", da_sleep, 1);
  endtask

  // monitor: sample 2 time units after the edge, after the driver has settled
  initial begin
    logic [14:0] e;
    forever begin
      @(posedge sys_clk);
      #2;
      if (mon_en) begin
        if (da_valid) begin
          n_seen++;
          if (first_cyc < 0) first_cyc = cyc;
          if (sb_q.size() == 0) check("sb_extra_sample", 1, 0);
          else begin
            e = sb_q.pop_front();
            check("da_data", da_data, e[13:0]);
            check("period_tick", period_tick, e[14]);
          end
        end else begin
          check("idle_da_data", da_data, 32'h2000);
        end
      end
    end
  end

  task automatic run(input logic [31:0] ftw, input logic [13:0] amp, input logic [15:0] ncyc,
                     input bit send_cfg, input int stop_at, input bit hold_en,
                     input logic [31:0] hold_ftw);
    int nexp, s_edge, wc;
    logic [31:0] ph;
    logic [32:0] sum;
    bit pend, term, t, got_done;
    if (send_cfg) begin
      cfg_valid = 1'b1; cfg_ftw = ftw; cfg_amp = amp; cfg_cycles = ncyc;
      sh_ftw = ftw; sh_amp = (amp > 14'd8192) ? 14'd8192 : amp; sh_cyc = ncyc;
    end
    start = 1'b1;
    first_cyc = -1;
    n_seen = 0;
    s_edge = cyc + 1;
    ph = 32'd0; wc = 0; pend = 1'b0; term = 1'b0; t = 1'b1; nexp = 0;
    while (!term && nexp < 4000) begin
      pend = pend | (nexp == stop_at);
      sb_q.push_back({t, exp_sample(ph, sh_amp)});
      nexp++;
      sum = {1'b0, ph} + {1'b0, sh_ftw};
      ph = sum[31:0];
      t = sum[32];
      if (sum[32]) wc++;
      term = (sum[32] && ((sh_cyc != 16'd0 && wc == int'(sh_cyc)) || pend)) || (pend && sh_ftw == 32'd0);
    end
    step();
    start = 1'b0;
    cfg_valid = 1'b0;
    check("busy_rise", busy, 1);
    check("sleep_low", da_sleep, 0);
    if (hold_en) begin
      cfg_valid = 1'b1;
      cfg_ftw = hold_ftw;
    end
    got_done = 1'b0;
    for (int i = 0; i < nexp + 40 && !got_done; i++) begin
      stop  = (stop_at >= 0) && (cyc == s_edge + 4 + stop_at);
      start = hold_en && (cyc == s_edge + 8);
      step();
      if (hold_en && cyc == s_edge + 6) check("cfg_ready_in_run", cfg_ready, 0);
      if (done) got_done = 1'b1;
    end
    stop = 1'b0;
    start = 1'b0;
    check("done_seen", got_done, 1);
    if (got_done) begin
      check("done_time", cyc, s_edge + 9 + nexp);
      check("first_valid_time", first_cyc, s_edge + 9);
      check("n_samples", n_seen, nexp);
      check("sb_empty", sb_q.size(), 0);
      check("sleep_after", da_sleep, 1);
      check("busy_fall", busy, 0);
      if (hold_en) check("cfg_ready_idle", cfg_ready, 1);
    end
    sb_q.delete();
    step();
    check("done_pulse_end", done, 0);
    if (hold_en) begin
      cfg_valid = 1'b0;
      sh_ftw = hold_ftw;
    end
  endtask

  task automatic reset_mid_run();
    mon_en = 1'b0;
    cfg_valid = 1'b1; cfg_ftw = 32'h1000_0000; cfg_amp = 14'd8192; cfg_cycles = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_valid = 1'b0;
    repeat (12) step();
    check("pre_reset_valid", da_valid, 1);
    sys_rst = 1'b1;
    step();
    check_reset_values();
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("no_done_after_reset", done, 0);
    end
    check("no_valid_after_reset", da_valid, 0);
    sb_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    sys_rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_ftw = 32'd0; cfg_amp = 14'd0; cfg_cycles = 16'd0;
    repeat (3) step();
    check_reset_values();
    check("da_clk_inverted", da_clk, !sys_clk);
    sys_rst = 1'b0;
    mon_en = 1'b1;
    step();
    run(32'h1000_0000, 14'd8192,  16'd2, 1'b1, -1, 1'b0, 32'd0);
    run(32'h1000_0000, 14'd4096,  16'd1, 1'b1, -1, 1'b0, 32'd0);
    run(32'h1000_0000, 14'd12000, 16'd1, 1'b1, -1, 1'b0, 32'd0);
    run(32'h0800_0000, 14'd8192,  16'd0, 1'b1, 40, 1'b0, 32'd0);
    run(32'h0000_0000, 14'd8192,  16'd0, 1'b1, 10, 1'b0, 32'd0);
    run(32'h1000_0000, 14'd8192,  16'd1, 1'b1, -1, 1'b1, 32'h2000_0000);
    run(32'd0, 14'd0, 16'd0, 1'b0, -1, 1'b0, 32'd0);
    run(32'h0400_0000, 14'd7000,  16'd1, 1'b1, -1, 1'b0, 32'd0);
    for (int r = 0; r < 2; r++)
      run($urandom_range(32'h2000_0000, 32'h0400_0000), 14'($urandom_range(16383, 0)),
          16'($urandom_range(3, 1)), 1'b1, -1, 1'b0, 32'd0);
    reset_mid_run();
    run(32'h1000_0000, 14'd8192, 16'd2, 1'b1, -1, 1'b0, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_dac_tx.md
Name: dds_dac_tx

Overview:
- Transmit-side counterpart of the 14-bit ADC capture path: a DDS sine generator feeding a 14-bit offset-binary DAC at sys_clk rate.
- Produces a configurable-frequency, configurable-amplitude sine burst (or continuous tone) for loopback into the ADC ports and for bench stimulus.
- Contains a phase accumulator, a quarter-wave ROM, an amplitude multiplier, a 5-stage output pipeline, and a run/burst control FSM with DAC sleep sequencing.

Parameters:
- PHASE_W, 32, phase accumulator width.
- DATA_W, 14, DAC sample width, offset binary.
- LUT_AW, 8, quarter-wave ROM address width (256 entries; full period = 1024 points).
- WAKE_CYC, 4, cycles da_sleep is held low before the first sample issues.

Ports:
- sys_clk  in  1  single clock, also the DAC sample rate.
- sys_rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready.
- cfg_ftw  in  PHASE_W  frequency tuning word.
- cfg_amp  in  14  amplitude; 8192 = unity; values above 8192 saturate to 8192.
- cfg_cycles  in  16  periods per burst; 0 = continuous.
- start  in  1  begin run (pulse).
- stop  in  1  request graceful stop (pulse).
- busy  out  1  high in WAKE, RUN, DRAIN.
- done  out  1  1-cycle pulse on DRAIN->IDLE.
- da_data  out  DATA_W  DAC sample.
- da_valid  out  1  da_data carries a generated sample.
- period_tick  out  1  high with the phase-0 sample of each period.
- da_clk  out  1  = ~sys_clk, so the DAC samples mid-cycle.
- da_sleep  out  1  DAC shutdown, high = asleep.

Behaviour:
- Reset values: cfg_ready=1, busy=0, done=0, da_data=14'h2000, da_valid=0, period_tick=0, da_sleep=1.
- Reset clears the FSM, the pipeline, and all counters. Reset mid-run takes effect at the next edge and the run is aborted with no done pulse.
- Config:
  - Captured into shadow registers on cfg_valid & cfg_ready.
  - cfg_ready is high only in IDLE.
  - If cfg_valid and start occur in the same IDLE cycle, the new config applies to this run.
- FSM states:
  - IDLE: start -> WAKE; da_sleep=1.
  - WAKE: da_sleep=0; after WAKE_CYC cycles -> RUN.
  - RUN: on the RUN-entry cycle phase=0; thereafter phase += ftw mod 2^PHASE_W each cycle.
  - DRAIN: 5 cycles, then -> IDLE with done=1 and da_sleep=1.
  - start outside IDLE is ignored.
- Issue and termination:
  - Each RUN cycle issues one sample.
  - A wrap is the carry out of the accumulator add; each wrap increments the period counter.
  - RUN ends, and the FSM moves to DRAIN, when either:
    - cfg_cycles != 0 and the wrap count reaches cfg_cycles; or
    - a stop is pending and a wrap occurs.
  - The sample at the terminating wrap (the next period's phase 0) is not issued.
  - stop is latched as pending. If ftw == 0, stop terminates on the next cycle instead of waiting for a wrap.
- Pipeline, latency 5: the sample issued k cycles after RUN entry appears on da_data at RUN-entry + k + 5.
  - S1: take the top 10 phase bits, quadrant q=p[9:8], idx=p[7:0].
  - S2: ROM read; lut[k] = round(8191*sin(pi/2*k/256)).
  - S3: fold by quadrant:
    - q0: +lut[idx].
    - q1: +lut[256-idx]; idx=0 gives +8191.
    - q2: -lut[idx].
    - q3: -lut[256-idx]; idx=0 gives -8191.
  - S4: s * amp (15-bit signed times 14-bit unsigned), arithmetic shift right 13 (floor).
  - S5: add 8192 and register. Output range is 1..16383; no overflow is possible.
- da_valid and period_tick travel alongside the samples.
- When da_valid=0, da_data = 14'h2000.

Test Plan:
- Single burst: ftw=32'h1000_0000, amp=8192, cycles=2, start → busy after 1 cycle; first da_valid at RUN-entry+5; 16 samples per period; samples 0, 4, 8, 12 = 0x2000, 0x3FFF, 0x2000, 0x0001; exactly 32 valid samples; period_tick on samples 0 and 16; done one cycle after 5 DRAIN cycles; da_sleep high after.
- Amplitude: same ftw, amp=4096 → peak 0x2000+4095=0x2FFF, trough 0x2000-4096=0x1000 (floor); amp=12000 → behaves as 8192.
- Continuous with stop: cycles=0, ftw=32'h0800_0000, stop pulsed at sample 40 → output continues to sample 63 (end of period 2), next sample not issued, then DRAIN and done.
- ftw=0 continuous: all samples 0x2000; stop → DRAIN next cycle, then done.
- Handshake: cfg_valid held during RUN → cfg_ready=0, no capture; capture occurs on return to IDLE. cfg_valid+start in the same cycle uses the new ftw.
- Reset mid-RUN: sys_rst for 1 cycle → next edge all outputs at reset values, no done pulse; a new start works normally.
